soda_vend_ctrl: RTL

//  Top-level FSM controller for the 70c three-soda vending machine, 100 Hz clock.
//  - Accepts one coin per cycle (N/I/Q/D) until credit >= PRICE, then waits for a selection (A/B/C).
//  - Drives the chosen vend line for 1 s and locks out coins meanwhile; no change is returned.
//  - Keeps a running total since the last R button operation and shows it on R release.

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/vend_timer.sv | 39 +++
 rtl/soda_vend_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared encodings, defaults and coin valuation for the three-soda vending controller.
package vend_pkg;

  localparam int DEFAULT_PRICE       = 70;
  localparam int DEFAULT_VEND_CYCLES = 100;
  localparam int DEFAULT_CREDIT_W    = 8;
  localparam int DEFAULT_TOTAL_W     = 16;

  localparam logic [1:0] COIN_N = 2'b00;
  localparam logic [1:0] COIN_I = 2'b01;
  localparam logic [1:0] COIN_Q = 2'b10;
  localparam logic [1:0] COIN_D = 2'b11;

  localparam logic [6:0] VALUE_N = 7'd5;
  localparam logic [6:0] VALUE_I = 7'd10;
  localparam logic [6:0] VALUE_Q = 7'd25;
  localparam logic [6:0] VALUE_D = 7'd100;

  localparam logic [1:0] SEL_A       = 2'b00;
  localparam logic [1:0] SEL_B       = 2'b01;
  localparam logic [1:0] SEL_C       = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    COLLECT,
    WAIT_SEL,
    VEND
  } state_e;

  function automatic logic [6:0] coin_value(input logic [1:0] coin_type);
    logic [6:0] value;
    value = VALUE_N;
    case (coin_type)
      COIN_N:  value = VALUE_N;
      COIN_I:  value = VALUE_I;
      COIN_Q:  value = VALUE_Q;
      COIN_D:  value = VALUE_D;
      default: value = VALUE_N;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter that times the vend-line pulse; done is high whenever the count is zero.
module vend_timer #(
  parameter int VEND_CYCLES = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic clear_i,
  output logic done_o
);

  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(VEND_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over load so an R release during the selection edge leaves the timer idle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/soda_vend_ctrl.sv
// Vending controller FSM: coin collection, selection, timed vend pulse and R-button total display.
module soda_vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = DEFAULT_PRICE,
  parameter int VEND_CYCLES = DEFAULT_VEND_CYCLES,
  parameter int CREDIT_W    = DEFAULT_CREDIT_W,
  parameter int TOTAL_W     = DEFAULT_TOTAL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                r_btn,
  output logic                coin_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                a_o,
  output logic                b_o,
  output logic                c_o,
  output logic [TOTAL_W-1:0]  total_disp,
  output logic                disp_valid
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic [TOTAL_W-1:0]  totalDisp_q, totalDisp_d;
  logic                dispValid_q, dispValid_d;
  logic [1:0]          selLatch_q, selLatch_d;
  logic                rBtnPrev_q;

  logic                rFall;
  logic [CREDIT_W-1:0] creditSum;
  logic [TOTAL_W:0]    totalSum;
  logic                timerLoad;
  logic                timerDone;
  logic                vendActive;

  assign rFall     = rBtnPrev_q & ~r_btn;
  assign creditSum = credit_q + CREDIT_W'(coin_value(coin_type));
  assign totalSum  = {1'b0, total_q} + (TOTAL_W + 1)'(coin_value(coin_type));

  vend_timer #(
    .VEND_CYCLES(VEND_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timerLoad),
    .clear_i(rFall),
    .done_o (timerDone)
  );

  // An R release overrides everything; otherwise coins/selections only count while R is up.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    total_d     = total_q;
    totalDisp_d = totalDisp_q;
    dispValid_d = 1'b0;
    selLatch_d  = selLatch_q;
    timerLoad   = 1'b0;
    if (rFall) begin
      totalDisp_d = total_q;
      dispValid_d = 1'b1;
      total_d     = '0;
      credit_d    = '0;
      state_d     = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (coin_valid && !r_btn) begin
            credit_d = creditSum;
            total_d  = totalSum[TOTAL_W] ? '1 : totalSum[TOTAL_W-1:0];
            if (creditSum >= CREDIT_W'(PRICE)) begin
              state_d = WAIT_SEL;
            end
          end
        end
        WAIT_SEL: begin
          if (sel_valid && !r_btn && (sel != SEL_ILLEGAL)) begin
            state_d    = VEND;
            credit_d   = '0;
            selLatch_d = sel;
            timerLoad  = 1'b1;
          end
        end
        VEND: begin
          if (timerDone) begin
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      credit_q    <= '0;
      total_q     <= '0;
      totalDisp_q <= '0;
      dispValid_q <= 1'b0;
      selLatch_q  <= SEL_A;
      rBtnPrev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      total_q     <= total_d;
      totalDisp_q <= totalDisp_d;
      dispValid_q <= dispValid_d;
      selLatch_q  <= selLatch_d;
      rBtnPrev_q  <= r_btn;
    end
  end

  // Vend lines decode straight from state so an async reset drops them without waiting for a clock.
  assign vendActive = (state_q == VEND);
  assign a_o        = vendActive && (selLatch_q == SEL_A);
  assign b_o        = vendActive && (selLatch_q == SEL_B);
  assign c_o        = vendActive && (selLatch_q == SEL_C);
  assign coin_ready = (state_q == COLLECT);
  assign credit     = credit_q;
  assign total_disp = totalDisp_q;
  assign disp_valid = dispValid_q;

endmodule
